// File: rtl/hamming84_decoder.sv
// Two-stage pipelined SECDED decoder for (8,4) extended Hamming code words.
// Corrects single-bit errors, flags double-bit errors, keeps saturating counts.
module hamming84_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [3:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
);

  logic             r_v1;
  logic [7:0]       r_code1;
  logic [2:0]       r_s1;
  logic             r_q1;
  logic             r_v2;
  logic [3:0]       r_data;
  logic             r_sec;
  logic             r_ded;
  logic [3:0]       r_syn;
  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] r_ded_cnt;

  logic [2:0] w_s;
  logic       w_q;
  logic       w_acc;
  logic       w_adv;
  logic       w_hs;
  logic [7:0] w_fix;
  logic       w_sec;
  logic       w_ded;
  logic [3:0] w_data;

  assign w_s[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
  assign w_s[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
  assign w_s[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
  assign w_q    = ^in_code;

  assign in_ready = !r_v1 || !r_v2 || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_adv    = r_v1 && (!r_v2 || out_ready);
  assign w_hs     = r_v2 && out_ready;

  // s names the 1-based Hamming position of a single error
  always_comb begin
    w_fix = r_code1;
    if (r_s1 != 3'd0 && r_q1)
      w_fix[r_s1 - 3'd1] = ~r_code1[r_s1 - 3'd1];
  end

  assign w_sec  = r_q1;
  assign w_ded  = (r_s1 != 3'd0) && !r_q1;
  assign w_data = {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_code1 <= 8'd0;
      r_s1    <= 3'd0;
      r_q1    <= 1'b0;
    end else if (w_acc) begin
      r_v1    <= 1'b1;
      r_code1 <= in_code;
      r_s1    <= w_s;
      r_q1    <= w_q;
    end else if (w_adv) begin
      r_v1    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_data <= 4'd0;
      r_sec  <= 1'b0;
      r_ded  <= 1'b0;
      r_syn  <= 4'd0;
    end else if (w_adv) begin
      r_v2   <= 1'b1;
      r_data <= w_data;
      r_sec  <= w_sec;
      r_ded  <= w_ded;
      r_syn  <= {r_q1, r_s1};
    end else if (w_hs) begin
      r_v2   <= 1'b0;
    end
  end

  // clear wins over a same-cycle flagged handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_hs) begin
      if (r_sec && r_sec_cnt != '1)
        r_sec_cnt <= r_sec_cnt + 1'b1;
      if (r_ded && r_ded_cnt != '1)
        r_ded_cnt <= r_ded_cnt + 1'b1;
    end
  end

  assign out_valid    = r_v2;
  assign out_data     = r_data;
  assign out_sec      = r_sec;
  assign out_ded      = r_ded;
  assign out_syndrome = r_syn;
  assign sec_count    = r_sec_cnt;
  assign ded_count    = r_ded_cnt;

endmodule
